// File: rtl/meas_logger.sv
// Measurement logger: writes tagged i2c samples into a BRAM ring with a header word at address 0.
// Optional build macro MEAS_LOGGER_TIMESTAMP_EN selects a free-running timestamp tag instead of a sequence number.
//
// state   | meaning
// IDLE    | waiting for an accepted strobe, no BRAM write
// WR_DATA | writing {tag, sample} at wr_ptr
// WR_HDR  | writing the header word at address 0
module meas_logger #(
  parameter int ADDR_W       = 11,
  parameter int TICKS_PER_MS = 100000
) (
  input  logic              clk100MHz,
  input  logic              rst,
  input  logic              log_enable,
  input  logic              meas_valid,
  input  logic [15:0]       meas_data,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [31:0]       bram_din,
  output logic              bram_we,
  output logic              busy,
  output logic              wrapped,
  output logic              overrun
);

  if (ADDR_W < 2 || ADDR_W > 30 || TICKS_PER_MS < 1) begin : g_param_check
    $error("meas_logger: ADDR_W must be 2..30 and TICKS_PER_MS at least 1");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_DATA = 2'd1,
    WR_HDR  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] PTR_FIRST = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PTR_LAST  = '1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr, ptr_d;
  logic [ADDR_W-1:0] addr_d;
  logic [31:0]       din_d;
  logic              we_d;
  logic              wrapped_d, overrun_d;
  logic              accept, drop;
  logic [15:0]       tag;

  assign accept = (state_q == IDLE) && meas_valid && log_enable;
  assign drop   = (state_q != IDLE) && meas_valid && log_enable;
  assign busy   = (state_q != IDLE);

`ifdef MEAS_LOGGER_TIMESTAMP_EN
  localparam int              PS_W    = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [PS_W-1:0] PS_LOAD = PS_W'(TICKS_PER_MS - 1);

  logic [PS_W-1:0] presc;
  logic [15:0]     tstamp;

  // Prescaler is a reloading down-counter; the timestamp steps on terminal count.
  always_ff @(posedge clk100MHz) begin
    if (rst) begin
      presc  <= PS_LOAD;
      tstamp <= 16'd0;
    end else if (presc == '0) begin
      presc  <= PS_LOAD;
      tstamp <= tstamp + 16'd1;
    end else begin
      presc  <= presc - 1'b1;
    end
  end

  assign tag = tstamp;
`else
  logic [15:0] seq_num;

  always_ff @(posedge clk100MHz) begin
    if (rst) begin
      seq_num <= 16'd0;
    end else if (accept) begin
      seq_num <= seq_num + 16'd1;
    end
  end

  assign tag = seq_num;
`endif

  always_ff @(posedge clk100MHz) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = WR_DATA;
      WR_DATA: state_d = WR_HDR;
      WR_HDR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered BRAM port; the header folds in a drop seen during WR_DATA.
  always_comb begin
    we_d      = 1'b0;
    addr_d    = bram_addr;
    din_d     = bram_din;
    ptr_d     = wr_ptr;
    wrapped_d = wrapped;
    overrun_d = overrun | drop;
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d   = 1'b1;
          addr_d = wr_ptr;
          din_d  = {tag, meas_data};
        end
      end
      WR_DATA: begin
        we_d      = 1'b1;
        addr_d    = '0;
        ptr_d     = (wr_ptr == PTR_LAST) ? PTR_FIRST : wr_ptr + PTR_FIRST;
        wrapped_d = wrapped | (wr_ptr == PTR_LAST);
        din_d     = {wrapped_d, overrun_d, {(30-ADDR_W){1'b0}}, ptr_d};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk100MHz) begin
    if (rst) begin
      bram_we   <= 1'b0;
      bram_addr <= '0;
      bram_din  <= 32'd0;
      wr_ptr    <= PTR_FIRST;
      wrapped   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      bram_we   <= we_d;
      bram_addr <= addr_d;
      bram_din  <= din_d;
      wr_ptr    <= ptr_d;
      wrapped   <= wrapped_d;
      overrun   <= overrun_d;
    end
  end

endmodule

// File: tb/tb_meas_logger.sv
// Self-checking bench for meas_logger: directed vector table, wrap and timestamp sequences,
// and randomized traffic against a transaction-level model of the BRAM write stream.
module tb_meas_logger;

  localparam int AW = 11;
  localparam int T  = 10;

  logic          clk100MHz = 1'b0;
  logic          rst = 1'b1;
  logic          log_enable = 1'b0;
  logic          meas_valid = 1'b0;
  logic [15:0]   meas_data = 16'd0;
  logic [AW-1:0] bram_addr;
  logic [31:0]   bram_din;
  logic          bram_we, busy, wrapped, overrun;

  meas_logger #(.ADDR_W(AW), .TICKS_PER_MS(T)) dut (
    .clk100MHz (clk100MHz),
    .rst       (rst),
    .log_enable(log_enable),
    .meas_valid(meas_valid),
    .meas_data (meas_data),
    .bram_addr (bram_addr),
    .bram_din  (bram_din),
    .bram_we   (bram_we),
    .busy      (busy),
    .wrapped   (wrapped),
    .overrun   (overrun)
  );

  always #5 clk100MHz = ~clk100MHz;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Model: pending BRAM writes in order, one per cycle; header contents resolved when issued.
  typedef struct {
    bit          hdr;
    logic [31:0] din;
  } wr_t;

  wr_t           q[$];
  int            cyc = 0;
  int            m_rst_cyc = 0;
  logic [AW-1:0] m_ptr = 1;
  bit            m_wrapped = 0, m_overrun = 0, m_cur_data = 0;
  logic [15:0]   m_seq = 0;
  logic          m_we = 0;
  logic [AW-1:0] m_addr = 0;
  logic [31:0]   m_din = 0;

  function automatic logic [15:0] model_tag();
`ifdef MEAS_LOGGER_TIMESTAMP_EN
    return 16'((cyc - 1 - m_rst_cyc) / T);
`else
    return m_seq;
`endif
  endfunction

  task automatic step(input bit r, input bit en, input bit v, input logic [15:0] d);
    wr_t e;
    rst = r; log_enable = en; meas_valid = v; meas_data = d;
    if (r) begin
      q.delete();
      m_ptr = 1; m_wrapped = 0; m_overrun = 0; m_seq = 0; m_rst_cyc = cyc;
      m_we = 0; m_addr = 0; m_din = 0; m_cur_data = 0;
    end else begin
      if (m_cur_data) begin
        if (m_ptr == {AW{1'b1}}) begin
          m_ptr = 1;
          m_wrapped = 1;
        end else begin
          m_ptr = m_ptr + 1'b1;
        end
      end
      if (v && en) begin
        if (m_we) m_overrun = 1;
        else begin
          q.push_back('{hdr: 1'b0, din: {model_tag(), d}});
          q.push_back('{hdr: 1'b1, din: 32'd0});
          m_seq = m_seq + 16'd1;
        end
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        m_we = 1;
        m_cur_data = !e.hdr;
        m_addr = e.hdr ? '0 : m_ptr;
        m_din = e.hdr ? {m_wrapped, m_overrun, {(30-AW){1'b0}}, m_ptr} : e.din;
      end else begin
        m_we = 0;
        m_cur_data = 0;
      end
    end
    @(posedge clk100MHz);
    #1;
    cyc++;
    chk("we", 32'(bram_we), 32'(m_we));
    chk("addr", 32'(bram_addr), 32'(m_addr));
    chk("din", bram_din, m_din);
    chk("busy", 32'(busy), 32'(m_we));
    chk("wrapped", 32'(wrapped), 32'(m_wrapped));
    chk("overrun", 32'(overrun), 32'(m_overrun));
  endtask

  typedef struct {
    bit            r, en, v;
    logic [15:0]   d;
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   din;
    logic          busy, wr, ov;
  } vec_t;

  vec_t vecs[15];

  task automatic setv(input int i, input bit r, input bit en, input bit v, input logic [15:0] d,
                      input logic we, input logic [AW-1:0] a, input logic [31:0] din,
                      input logic b, input logic w, input logic o);
    vecs[i] = '{r: r, en: en, v: v, d: d, we: we, addr: a, din: din, busy: b, wr: w, ov: o};
  endtask

  initial begin
    int wecount;

    // Expected outputs are those seen in the cycle after the row's inputs.
    setv(0,  1, 1, 0, 16'h0000, 0, 11'h000, 32'h0000_0000, 0, 0, 0);
    setv(1,  0, 1, 1, 16'h1A2B, 1, 11'h001, 32'h0000_1A2B, 1, 0, 0);
    setv(2,  0, 1, 1, 16'hBEEF, 1, 11'h000, 32'h4000_0002, 1, 0, 1);
    setv(3,  0, 1, 0, 16'h0000, 0, 11'h000, 32'h4000_0002, 0, 0, 1);
    setv(4,  0, 0, 1, 16'h1111, 0, 11'h000, 32'h4000_0002, 0, 0, 1);
    setv(5,  0, 1, 1, 16'h2222, 1, 11'h002, 32'h0001_2222, 1, 0, 1);
    setv(6,  0, 0, 0, 16'h0000, 1, 11'h000, 32'h4000_0003, 1, 0, 1);
    setv(7,  0, 0, 0, 16'h0000, 0, 11'h000, 32'h4000_0003, 0, 0, 1);
    setv(8,  1, 0, 0, 16'h0000, 0, 11'h000, 32'h0000_0000, 0, 0, 0);
    setv(9,  0, 1, 1, 16'h3333, 1, 11'h001, 32'h0000_3333, 1, 0, 0);
    setv(10, 1, 1, 0, 16'h0000, 0, 11'h000, 32'h0000_0000, 0, 0, 0);
    setv(11, 0, 1, 1, 16'h4444, 1, 11'h001, 32'h0000_4444, 1, 0, 0);
    setv(12, 0, 1, 0, 16'h0000, 1, 11'h000, 32'h0000_0002, 1, 0, 0);
    setv(13, 0, 1, 1, 16'h5555, 0, 11'h000, 32'h0000_0002, 0, 0, 1);
    setv(14, 1, 1, 1, 16'h6666, 0, 11'h000, 32'h0000_0000, 0, 0, 0);

`ifndef MEAS_LOGGER_TIMESTAMP_EN
    for (int i = 0; i < 15; i++) begin
      step(vecs[i].r, vecs[i].en, vecs[i].v, vecs[i].d);
      chk($sformatf("vec%0d_we", i), 32'(bram_we), 32'(vecs[i].we));
      chk($sformatf("vec%0d_addr", i), 32'(bram_addr), 32'(vecs[i].addr));
      chk($sformatf("vec%0d_din", i), bram_din, vecs[i].din);
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      chk($sformatf("vec%0d_wrapped", i), 32'(wrapped), 32'(vecs[i].wr));
      chk($sformatf("vec%0d_overrun", i), 32'(overrun), 32'(vecs[i].ov));
    end
`else
    step(1, 1, 0, 16'h0);
    for (int i = 0; i < 34; i++) step(0, 1, 0, 16'h0);
    step(0, 1, 1, 16'hABCD);
    chk("ts_we", 32'(bram_we), 32'd1);
    chk("ts_tag", 32'(bram_din[31:16]), 32'd3);
    chk("ts_data", 32'(bram_din[15:0]), 32'h0000_ABCD);
`endif

    // Disabled logging: strobes must leave no trace.
    step(1, 0, 0, 16'h0);
    wecount = 0;
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 1'($urandom_range(0, 1)), 16'($urandom));
      if (bram_we) wecount++;
    end
    chk("disabled_we_count", 32'(wecount), 32'd0);
    chk("disabled_overrun", 32'(overrun), 32'd0);

    // Fill the whole data area once and wrap.
    step(1, 1, 0, 16'h0);
    for (int i = 0; i < 2047; i++) begin
      step(0, 1, 1, 16'($urandom));
      if (i == 2046) begin
        chk("wrap_last_addr", 32'(bram_addr), 32'h7FF);
        chk("wrap_last_we", 32'(bram_we), 32'd1);
      end
      step(0, 1, 0, 16'h0);
      if (i == 2046) begin
        chk("wrap_hdr", bram_din, 32'h8000_0001);
        chk("wrap_flag", 32'(wrapped), 32'd1);
      end
      step(0, 1, 0, 16'h0);
      step(0, 1, 0, 16'h0);
    end
    step(0, 1, 1, 16'h7777);
    chk("wrap_next_addr", 32'(bram_addr), 32'd1);
    chk("wrap_next_we", 32'(bram_we), 32'd1);

    // Randomized traffic, including resets mid-sequence.
    step(1, 1, 0, 16'h0);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) == 0), 16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/meas_logger.md
MEAS_LOGGER -- requirements
Module: meas_logger

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, the BRAM port-B address width; the buffer holds 2^ADDR_W 32-bit words.
REQ-002 SHALL have parameter TICKS_PER_MS, default 100000, the number of clk100MHz cycles per timestamp tick.
REQ-003 SHALL have port clk100MHz, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-005 SHALL have port log_enable, input, 1 bit; when high, samples are accepted.
REQ-006 SHALL have port meas_valid, input, 1 bit, a one-cycle strobe marking a new sample from the i2c master.
REQ-007 SHALL have port meas_data, input, 16 bits, the measurement word, valid when meas_valid=1.
REQ-008 SHALL have port bram_addr, output, ADDR_W bits, the port-B write address.
REQ-009 SHALL have port bram_din, output, 32 bits, the port-B write data.
REQ-010 SHALL have port bram_we, output, 1 bit, the port-B write enable.
REQ-011 SHALL have port busy, output, 1 bit, high whenever the FSM is not in IDLE.
REQ-012 SHALL have port wrapped, output, 1 bit, a sticky flag set once the data pointer wraps.
REQ-013 SHALL have port overrun, output, 1 bit, a sticky flag set when a sample is dropped.

Function
REQ-014 Address 0 SHALL be the header word; data SHALL occupy addresses 1..2^ADDR_W-1.
REQ-015 Header word SHALL be {wrapped, overrun, (30-ADDR_W) zeros, wr_ptr}, where wr_ptr is the next data address.
REQ-016 Data word SHALL be {tag[15:0], meas_data}; the tag source is set by REQ-032/REQ-033.
REQ-017 FSM states SHALL be IDLE, WR_DATA, WR_HDR; there SHALL be no other reachable state.
REQ-018 IDLE SHALL transition to WR_DATA on meas_valid=1 with log_enable=1, registering meas_data and the tag in that cycle.
REQ-019 In WR_DATA, bram_we SHALL be 1, bram_addr SHALL be wr_ptr, bram_din SHALL be the data word, and wr_ptr SHALL then advance.
REQ-020 WR_DATA SHALL always go to WR_HDR.
REQ-021 In WR_HDR, bram_we SHALL be 1, bram_addr SHALL be 0, and bram_din SHALL be the header using the updated wr_ptr and flags.
REQ-022 WR_HDR SHALL always go to IDLE; a strobe accepted at cycle N SHALL produce the data write at N+1, the header write at N+2, and IDLE at N+3.
REQ-023 In IDLE, bram_we SHALL be 0; bram_addr and bram_din SHALL hold their last values.
REQ-024 Wrap: advancing from 2^ADDR_W-1 SHALL set wr_ptr to 1, never 0, and SHALL set wrapped.
REQ-025 meas_valid=1 while busy=1 SHALL drop the sample, set overrun, and leave wr_ptr and the tag unchanged.
REQ-026 meas_valid=1 with log_enable=0 SHALL be ignored silently, with no write and no overrun.
REQ-027 Deasserting log_enable mid-sequence SHALL NOT abort it; WR_DATA and WR_HDR SHALL complete.
REQ-028 wrapped and overrun SHALL clear only on rst.

Reset
REQ-029 rst=1 SHALL force state IDLE, wr_ptr=1, bram_we=0, bram_addr=0, bram_din=0, busy=0, wrapped=0, overrun=0, tag counters=0 at the next edge.
REQ-030 rst during WR_DATA or WR_HDR SHALL abort the sequence, with bram_we=0 in the cycle after the reset edge; the partial header is not repaired.
REQ-031 rst SHALL take priority over every simultaneous input event.

Configuration
REQ-032 With MEAS_LOGGER_TIMESTAMP_EN defined, the tag SHALL be a 16-bit free-running timestamp.
- Incremented once every TICKS_PER_MS cycles by a prescaler.
- Wraps 0xFFFF->0x0000.
- Runs regardless of log_enable.
REQ-033 Without MEAS_LOGGER_TIMESTAMP_EN, the tag SHALL be a 16-bit sequence number.
- Incremented once per accepted sample.
- Wraps 0xFFFF->0x0000.
- No prescaler logic is synthesized.

Verification
REQ-034 Reset, log_enable=1, one strobe with meas_data=0x1A2B (sequence build):
- -> N+1: addr=1, din=0x00001A2B, we=1.
- -> N+2: addr=0, din=0x00000002, we=1.
- -> N+3: we=0, busy=0.
REQ-035 Second strobe at N+1:
- -> dropped, overrun=1.
- -> next header at addr 0 = 0x40000002.
REQ-036 2047 strobes spaced 4 cycles apart:
- -> last data at addr 0x7FF, wr_ptr=1, wrapped=1.
- -> header 0x80000001.
- -> 2048th strobe writes addr 1.
REQ-037 log_enable=0 with strobes -> no bram_we pulses, overrun=0.
REQ-038 rst asserted in the WR_DATA cycle:
- -> bram_we=0 at the following cycle.
- -> next strobe writes addr 1 with tag 0.
REQ-039 Timestamp build with TICKS_PER_MS=10:
- Strobe after 35 cycles from reset -> data tag=3.
